// File: rtl/alu181_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu181_pkg
// Description : Shared constants and types for the pipelined 74181-style ALU.
//               Function-select encodings, mode encodings, slice width and
//               the registered status-flag bundle with its reset value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package alu181_pkg;

  // Width of one ALU slice; the datapath is built from WIDTH/SLICE_W slices.
  localparam int SLICE_W = 4;

  // Function selects. S_SUB and S_XOR share an encoding and differ only by m;
  // likewise S_PASSA and S_DEC.
  localparam logic [3:0] S_ADD   = 4'b1001;
  localparam logic [3:0] S_SUB   = 4'b0110;
  localparam logic [3:0] S_PASSA = 4'b1111;
  localparam logic [3:0] S_XOR   = 4'b0110;
  localparam logic [3:0] S_DEC   = 4'b1111;

  // Mode select.
  localparam logic M_LOGIC = 1'b1;
  localparam logic M_ARITH = 1'b0;

  // Status flags captured alongside the result in the output stage.
  typedef struct packed {
    logic co_n;
    logic a_eq_b;
    logic zero;
    logic ovf;
  } flags_t;

  // Flags describing y == 0 with no carry out and no overflow.
  localparam flags_t FLAGS_RST = '{co_n: 1'b1, a_eq_b: 1'b0, zero: 1'b1, ovf: 1'b0};

endpackage : alu181_pkg
`default_nettype wire

// File: rtl/alu181_slice.sv
`default_nettype none
// ============================================================================
// Module      : alu181_slice
// Description : Combinational 4-bit 74181-style function slice. Forms the
//               per-bit T1/T2 terms, the logic-mode result, group
//               propagate/generate for the lookahead chain, and the
//               arithmetic sum from an externally supplied carry in.
// Ports       : a, b     - 4-bit operands (a already muxed with accumulator)
//               s        - function select
//               ci       - active-high carry into bit 0 of this slice
//               logic_y  - logic-mode result ~(T1 ^ T2)
//               sum      - arithmetic sum T1 + T2 + ci (low 4 bits)
//               grp_p    - group propagate
//               grp_g    - group generate
// Revision    : 1.0 - initial release
// ============================================================================
module alu181_slice
  import alu181_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [3:0]         s,
  input  logic               ci,
  output logic [SLICE_W-1:0] logic_y,
  output logic [SLICE_W-1:0] sum,
  output logic               grp_p,
  output logic               grp_g
);

  logic [SLICE_W-1:0] t1;
  logic [SLICE_W-1:0] t2;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] c;

  // Carry-independent terms. Kept apart from the carry logic so the
  // group P/G outputs have no path from ci; the top's lookahead chain
  // feeds ci back from these outputs.
  always_comb begin
    t1 = a | (b & {SLICE_W{s[0]}}) | (~b & {SLICE_W{s[1]}});
    t2 = (a & ~b & {SLICE_W{s[2]}}) | (a & b & {SLICE_W{s[3]}});
    p  = t1 ^ t2;
    g  = t1 & t2;
    logic_y = ~p;
    grp_p = &p;
    grp_g = g[0];
    for (int i = 1; i < SLICE_W; i++) begin
      grp_g = g[i] | (p[i] & grp_g);
    end
  end

  // Internal ripple across the four bits of the slice.
  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 1; i < SLICE_W; i++) begin
      c[i] = g[i-1] | (p[i-1] & c[i-1]);
    end
    sum = p ^ c;
  end

endmodule : alu181_slice
`default_nettype wire

// File: rtl/alu181_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu181_pipe
// Description : WIDTH-bit 74181-style ALU with a two-stage valid/ready
//               pipeline, full backpressure, an accumulator operand and
//               registered zero / all-ones / carry / signed-overflow flags.
//               Stage A registers the operation; the function is evaluated
//               combinationally from stage A and captured into stage B.
// Ports       : clk, rst_n          - clock, async active-low reset
//               in_valid/in_ready   - operation handshake
//               a, b, s, m, ci_n    - operands, select, mode, carry in (low)
//               acc_en              - use accumulator in place of a
//               out_valid/out_ready - result handshake
//               y, co_n, a_eq_b,
//               zero, ovf           - registered result and flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu181_pipe
  import alu181_pkg::*;
#(
  parameter int WIDTH = 8  // multiple of 4, at least 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             ci_n,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             co_n,
  output logic             a_eq_b,
  output logic             zero,
  output logic             ovf
);

  localparam int NS = WIDTH / SLICE_W;

  // Stage A: registered operation.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             ci_n_q, ci_n_d;
  logic             acc_en_q, acc_en_d;
  logic             a_vld_q, a_vld_d;

  // Stage B: registered result.
  logic [WIDTH-1:0] y_q, y_d;
  flags_t           flags_q, flags_d;
  logic             b_vld_q, b_vld_d;

  // Accumulator operand.
  logic [WIDTH-1:0] acc_q, acc_d;

  // Handshake.
  logic b_adv;
  logic a_adv;
  logic load;

  // Datapath.
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] logic_all;
  logic [WIDTH-1:0] sum_all;
  logic [NS-1:0]    grp_p;
  logic [NS-1:0]    grp_g;
  logic [NS:0]      grp_c;
  logic [WIDTH-1:0] res_y;
  flags_t           res_flags;
  logic             c_into_msb;

  // --------------------------------------------------------------------------
  // Handshake: stage B frees up when empty or being consumed; stage A moves
  // into B whenever B can accept, and takes a new op in the same cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    b_adv    = ~b_vld_q | out_ready;
    a_adv    = a_vld_q & b_adv;
    in_ready = ~a_vld_q | b_adv;
    load     = in_valid & in_ready;
  end

  // --------------------------------------------------------------------------
  // Function evaluation from stage A.
  // --------------------------------------------------------------------------
  always_comb begin
    op_a = acc_en_q ? acc_q : a_q;
  end

  for (genvar i = 0; i < NS; i++) begin : g_slice
    alu181_slice u_slice (
      .a       (op_a[i*SLICE_W +: SLICE_W]),
      .b       (b_q[i*SLICE_W +: SLICE_W]),
      .s       (s_q),
      .ci      (grp_c[i]),
      .logic_y (logic_all[i*SLICE_W +: SLICE_W]),
      .sum     (sum_all[i*SLICE_W +: SLICE_W]),
      .grp_p   (grp_p[i]),
      .grp_g   (grp_g[i])
    );
  end

  // Slice-level carry chain driven by group propagate/generate.
  always_comb begin
    grp_c    = '0;
    grp_c[0] = ~ci_n_q;
    for (int i = 0; i < NS; i++) begin
      grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
    end
  end

  always_comb begin
    res_y = m_q ? logic_all : sum_all;
    // The logic result is ~(T1 ^ T2), i.e. the inverted bit propagate, so the
    // carry into the MSB falls out of sum = propagate ^ carry_in.
    c_into_msb       = sum_all[WIDTH-1] ^ ~logic_all[WIDTH-1];
    res_flags.co_n   = m_q ? 1'b1 : ~grp_c[NS];
    res_flags.ovf    = m_q ? 1'b0 : (c_into_msb ^ grp_c[NS]);
    res_flags.a_eq_b = &res_y;
    res_flags.zero   = ~|res_y;
  end

  // --------------------------------------------------------------------------
  // Next-state.
  // --------------------------------------------------------------------------
  always_comb begin
    a_d      = load ? a      : a_q;
    b_d      = load ? b      : b_q;
    s_d      = load ? s      : s_q;
    m_d      = load ? m      : m_q;
    ci_n_d   = load ? ci_n   : ci_n_q;
    acc_en_d = load ? acc_en : acc_en_q;
    a_vld_d  = load | (a_vld_q & ~a_adv);

    y_d      = a_adv ? res_y     : y_q;
    flags_d  = a_adv ? res_flags : flags_q;
    b_vld_d  = a_adv | (b_vld_q & ~out_ready);

    // Every op that leaves stage A updates the accumulator, so a following
    // acc_en op already sees the new value with no bubble.
    acc_d    = a_adv ? res_y : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      ci_n_q   <= 1'b1;
      acc_en_q <= 1'b0;
      a_vld_q  <= 1'b0;
      y_q      <= '0;
      flags_q  <= FLAGS_RST;
      b_vld_q  <= 1'b0;
      acc_q    <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      m_q      <= m_d;
      ci_n_q   <= ci_n_d;
      acc_en_q <= acc_en_d;
      a_vld_q  <= a_vld_d;
      y_q      <= y_d;
      flags_q  <= flags_d;
      b_vld_q  <= b_vld_d;
      acc_q    <= acc_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs come straight from stage B, so they hold while stalled.
  // --------------------------------------------------------------------------
  always_comb begin
    out_valid = b_vld_q;
    y         = y_q;
    co_n      = flags_q.co_n;
    a_eq_b    = flags_q.a_eq_b;
    zero      = flags_q.zero;
    ovf       = flags_q.ovf;
  end

endmodule : alu181_pipe
`default_nettype wire
